// File: rtl/comparador_serial_param.sv
// rtl/comparador_serial_param.sv - bit-serial sliding-window comparator against a loadable constant
// Modes EQ/GT/LT/NE, registered match pulse, saturating match counter.
module comparador_serial_param #(
  parameter int                 WIDTH         = 4,
  parameter logic [WIDTH-1:0]   CONST_DEFAULT = 'b0101,
  parameter int                 CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic             d_in,
  input  logic             load,
  input  logic [WIDTH-1:0] k_in,
  input  logic [1:0]       mode,
  input  logic             overlap,
  input  logic             clr_cnt,
  output logic             Q,
  output logic             armed,
  output logic [CNT_W-1:0] match_count
);

  localparam int FW = $clog2(WIDTH + 1);

  typedef enum logic {FILL, ARMED} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] k;
  logic [FW-1:0]    fill_cnt;
  logic [WIDTH-1:0] window;
  logic             hit;
  logic             fill_done;
  logic             compare_en;
  logic             match;
  logic             q_nxt;
  logic             armed_nxt;

  assign window     = {sr[WIDTH-2:0], d_in};
  assign fill_done  = (state == FILL) && (fill_cnt == FW'(WIDTH - 1));
  assign compare_en = valid_in && !load && ((state == ARMED) || fill_done);
  assign match      = compare_en && hit;

  always_comb begin
    hit = 1'b0;
    case (mode)
      2'b00:   hit = (window == k);
      2'b01:   hit = (window > k);
      2'b10:   hit = (window < k);
      default: hit = (window != k);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (load) begin
      state_nxt = FILL;
    end else if (valid_in) begin
      if (match && !overlap)
        state_nxt = FILL;
      else if (fill_done)
        state_nxt = ARMED;
    end
  end

  always_comb begin
    q_nxt     = match;
    armed_nxt = (state_nxt == ARMED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr          <= '0;
      k           <= CONST_DEFAULT;
      fill_cnt    <= '0;
      Q           <= 1'b0;
      armed       <= 1'b0;
      match_count <= '0;
    end else begin
      Q     <= q_nxt;
      armed <= armed_nxt;
      if (load) begin
        // The beat arriving with load is discarded; the window refills from scratch.
        k        <= k_in;
        sr       <= '0;
        fill_cnt <= '0;
      end else if (valid_in) begin
        sr <= window;
        if (match && !overlap)
          fill_cnt <= '0;
        else if (state == FILL)
          fill_cnt <= fill_cnt + 1'b1;
      end
      if (clr_cnt)
        match_count <= q_nxt ? CNT_W'(1) : '0;
      else if (q_nxt && !(&match_count))
        match_count <= match_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_comparador_serial_param.sv
// tb/tb_comparador_serial_param.sv - scoreboard bench for comparador_serial_param
// Two instances share stimulus; the second has a 2-bit counter for saturation checks.
module tb_comparador_serial_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid_in = 1'b0;
  logic       d_in = 1'b0;
  logic       load = 1'b0;
  logic [3:0] k_in = 4'b0000;
  logic [1:0] mode = 2'b00;
  logic       overlap = 1'b1;
  logic       clr_cnt = 1'b0;
  logic       q, armed, q2, armed2;
  logic [7:0] count;
  logic [1:0] count2;

  int tests_run = 0;
  int tests_failed = 0;
  logic sb[$];

  always #5 clk = ~clk;

  comparador_serial_param #(.WIDTH(4), .CONST_DEFAULT(4'b0101), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .d_in(d_in), .load(load), .k_in(k_in),
    .mode(mode), .overlap(overlap), .clr_cnt(clr_cnt),
    .Q(q), .armed(armed), .match_count(count)
  );

  comparador_serial_param #(.WIDTH(4), .CONST_DEFAULT(4'b0101), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .d_in(d_in), .load(load), .k_in(k_in),
    .mode(mode), .overlap(overlap), .clr_cnt(clr_cnt),
    .Q(q2), .armed(armed2), .match_count(count2)
  );

  // Expected Q for each driven cycle is popped one cycle after it was pushed.
  always @(posedge clk) begin
    logic exp_q;
    #1;
    if (sb.size() > 0) begin
      exp_q = sb.pop_front();
      tests_run++;
      if (q !== exp_q) begin
        tests_failed++;
        $display("FAIL q_pulse t=%0t got=%b want=%b", $time, q, exp_q);
      end
    end
  end

  task automatic drive(input logic v, input logic d, input logic ld, input logic [3:0] kk,
                       input logic clr, input logic exp_q);
    valid_in = v;
    d_in     = d;
    load     = ld;
    k_in     = kk;
    clr_cnt  = clr;
    sb.push_back(exp_q);
    @(posedge clk);
    #2;
    valid_in = 1'b0;
    load     = 1'b0;
    clr_cnt  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    valid_in = 1'b0;
    load = 1'b0;
    clr_cnt = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run += 3;
    if (q !== 1'b0)     begin tests_failed++; $display("FAIL reset_q got=%b want=0", q); end
    if (armed !== 1'b0) begin tests_failed++; $display("FAIL reset_armed got=%b want=0", armed); end
    if (count !== 8'd0) begin tests_failed++; $display("FAIL reset_count got=%0d want=0", count); end
  endtask

  task automatic test_defaults_match();
    do_reset();
    mode = 2'b00; overlap = 1'b1;
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    tests_run++;
    if (armed !== 1'b0) begin tests_failed++; $display("FAIL armed_before_fill got=%b want=0", armed); end
    drive(1, 1, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0);
    tests_run += 2;
    if (armed !== 1'b1) begin tests_failed++; $display("FAIL armed_after_fill got=%b want=1", armed); end
    if (count !== 8'd1) begin tests_failed++; $display("FAIL defaults_count got=%0d want=1", count); end
  endtask

  task automatic test_overlap();
    logic [5:0] bits = 6'b010101;
    logic [5:0] exp_ov = 6'b000101;
    logic [5:0] exp_no = 6'b000100;
    do_reset();
    mode = 2'b00; overlap = 1'b1;
    for (int i = 5; i >= 0; i--) drive(1, bits[i], 0, 0, 0, exp_ov[i]);
    tests_run++;
    if (count !== 8'd2) begin tests_failed++; $display("FAIL overlap1_count got=%0d want=2", count); end
    do_reset();
    overlap = 1'b0;
    for (int i = 5; i >= 0; i--) drive(1, bits[i], 0, 0, 0, exp_no[i]);
    tests_run += 2;
    if (armed !== 1'b0) begin tests_failed++; $display("FAIL overlap0_armed got=%b want=0", armed); end
    if (count !== 8'd1) begin tests_failed++; $display("FAIL overlap0_count got=%0d want=1", count); end
  endtask

  task automatic test_modes_gaps();
    logic [3:0] gt_bits = 4'b0110;
    do_reset();
    mode = 2'b01; overlap = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      drive(1, gt_bits[i], 0, 0, 0, i == 0);
      if (i != 0) drive(0, 0, 0, 0, 0, 0);
    end
    // Window 0110; LT feed 0,1,0,0 -> 1100, 1001, 0010, 0100 against k=0101.
    mode = 2'b10;
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 0);
    tests_run++;
    if (count !== 8'd3) begin tests_failed++; $display("FAIL modes_count got=%0d want=3", count); end
    do_reset();
    mode = 2'b10;
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    mode = 2'b11;
    drive(1, 0, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 0);
  endtask

  task automatic test_load_midstream();
    do_reset();
    mode = 2'b00; overlap = 1'b1;
    drive(1, 1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 4'b1100, 0, 0);
    tests_run++;
    if (armed !== 1'b0) begin tests_failed++; $display("FAIL load_armed got=%b want=0", armed); end
    drive(1, 1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1);
    // Window 1100 -> 1001, 0011, 0110; the would-be match on the next beat is swallowed by load.
    drive(1, 1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 4'b1100, 0, 0);
    tests_run += 2;
    if (count !== 8'd1) begin tests_failed++; $display("FAIL load_count got=%0d want=1", count); end
    if (armed !== 1'b0) begin tests_failed++; $display("FAIL load2_armed got=%b want=0", armed); end
  endtask

  task automatic test_counter();
    do_reset();
    mode = 2'b00; overlap = 1'b1;
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 0, 0);
      drive(1, 1, 0, 0, 0, 1);
    end
    tests_run += 2;
    if (count2 !== 2'd3) begin tests_failed++; $display("FAIL count_saturate got=%0d want=3", count2); end
    if (count !== 8'd5)  begin tests_failed++; $display("FAIL count_wide got=%0d want=5", count); end
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 1, 1);
    tests_run += 2;
    if (count2 !== 2'd1) begin tests_failed++; $display("FAIL clr_with_match got=%0d want=1", count2); end
    if (count !== 8'd1)  begin tests_failed++; $display("FAIL clr_with_match_wide got=%0d want=1", count); end
    drive(0, 0, 0, 0, 1, 0);
    tests_run++;
    if (count !== 8'd0) begin tests_failed++; $display("FAIL clr_plain got=%0d want=0", count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mode = 2'b00; overlap = 1'b1;
    drive(0, 0, 1, 4'b1111, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    do_reset();
    tests_run += 3;
    if (q !== 1'b0)     begin tests_failed++; $display("FAIL rstmid_q got=%b want=0", q); end
    if (armed !== 1'b0) begin tests_failed++; $display("FAIL rstmid_armed got=%b want=0", armed); end
    if (count !== 8'd0) begin tests_failed++; $display("FAIL rstmid_count got=%0d want=0", count); end
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0);
    tests_run++;
    if (count !== 8'd1) begin tests_failed++; $display("FAIL rstmid_after_count got=%0d want=1", count); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_defaults_match();
    test_overlap();
    test_modes_gaps();
    test_load_midstream();
    test_counter();
    test_reset_mid();
    @(posedge clk);
    #3;
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
